// File: rtl/logic_input_sequencer.sv
// Stimulus sequencer that walks the eight {B,C,D} combinations with a valid/ready handshake.
// Optional build macro GRAY_ORDER_EN selects Gray-coded output order instead of binary.
module logic_input_sequencer #(
  parameter int HOLD_CYCLES = 4,
  parameter int LOOP        = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       step_mode,
  input  logic       step,
  input  logic       ready,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       valid,
  output logic [2:0] index,
  output logic       busy,
  output logic       done,
  output logic [1:0] state_dbg_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  // Handshake: a combination is offered while valid=1 and is consumed on any
  // rising edge where the advance condition (hold elapsed or step) meets ready=1;
  // with ready=0 the combination is held unchanged and valid stays high.

  logic [1:0] state_q, state_d;
  logic [2:0] index_q, index_d;
  logic [7:0] hold_q,  hold_d;
  logic [2:0] bcd_q,   bcd_d;
  logic       valid_q, valid_d;
  logic       busy_q,  busy_d;
  logic       done_q,  done_d;

  logic       hold_done;
  logic       advance;

  function automatic logic [2:0] map_combo(input logic [2:0] idx);
`ifdef GRAY_ORDER_EN
    return idx ^ (idx >> 1);
`else
    return idx;
`endif
  endfunction

  assign hold_done = (hold_q == HOLD_LAST);
  assign advance   = ready && (step_mode ? step : hold_done);

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    hold_d  = hold_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRIVE;
          index_d = 3'd0;
          hold_d  = 8'd0;
        end
      end

      S_DRIVE: begin
        // The counter keeps running in step mode so a mode switch keeps its value.
        if (!hold_done) begin
          hold_d = hold_q + 8'd1;
        end
        if (advance) begin
          hold_d = 8'd0;
          if (index_q != 3'd7) begin
            index_d = index_q + 3'd1;
          end else if (LOOP != 0) begin
            index_d = 3'd0;
          end else begin
            state_d = S_DONE;
            hold_d  = hold_q;
          end
        end
      end

      S_DONE: begin
        if (start) begin
          state_d = S_DRIVE;
          index_d = 3'd0;
          hold_d  = 8'd0;
        end
      end

      default: begin
        state_d = S_IDLE;
        index_d = 3'd0;
        hold_d  = 8'd0;
      end
    endcase

    if (stop) begin
      state_d = S_IDLE;
      index_d = 3'd0;
      hold_d  = 8'd0;
    end
  end

  // Outputs are computed from the next state so every port comes straight from a flop.
  always_comb begin
    valid_d = (state_d == S_DRIVE);
    busy_d  = (state_d == S_DRIVE);
    done_d  = (state_d == S_DONE);
    bcd_d   = 3'd0;
    if (state_d != S_IDLE) begin
      bcd_d = map_combo(index_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      index_q <= 3'd0;
      hold_q  <= 8'd0;
      bcd_q   <= 3'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      hold_q  <= hold_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign B           = bcd_q[2];
  assign C           = bcd_q[1];
  assign D           = bcd_q[0];
  assign valid       = valid_q;
  assign index       = index_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_logic_input_sequencer.sv
// Bench for logic_input_sequencer: two instances (HOLD 4 no-loop, HOLD 2 loop) driven in lockstep.
module tb_logic_input_sequencer;

  localparam int HOLD0 = 4;
  localparam int HOLD1 = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic start, stop, step_mode, step, ready;

  logic [1:0] b_w, c_w, d_w, valid_w, busy_w, done_w;
  logic [2:0] idx_w [2];
  logic [1:0] st_w  [2];

  always #5 clk = ~clk;

  logic_input_sequencer #(.HOLD_CYCLES(HOLD0), .LOOP(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step_mode(step_mode),
    .step(step), .ready(ready), .B(b_w[0]), .C(c_w[0]), .D(d_w[0]),
    .valid(valid_w[0]), .index(idx_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .state_dbg_o(st_w[0])
  );

  logic_input_sequencer #(.HOLD_CYCLES(HOLD1), .LOOP(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step_mode(step_mode),
    .step(step), .ready(ready), .B(b_w[1]), .C(c_w[1]), .D(d_w[1]),
    .valid(valid_w[1]), .index(idx_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .state_dbg_o(st_w[1])
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase 0 idle, 1 driving, 2 finished; dwell counts cycles shown.
  int m_phase [2];
  int m_idx   [2];
  int m_dwell [2];
  int hold_p  [2] = '{HOLD0, HOLD1};
  int loop_p  [2] = '{0, 1};
  logic [2:0] gray_tab [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

  function automatic logic [2:0] combo(input int idx);
`ifdef GRAY_ORDER_EN
    return gray_tab[idx];
`else
    return 3'(idx);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0;
      m_idx[i]   = 0;
      m_dwell[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    bit adv;
    if (stop) begin
      m_phase[i] = 0; m_idx[i] = 0; m_dwell[i] = 0;
    end else if (m_phase[i] == 1) begin
      adv = step_mode ? (step && ready) : (m_dwell[i] >= hold_p[i] && ready);
      if (!adv) begin
        m_dwell[i]++;
      end else if (m_idx[i] < 7) begin
        m_idx[i]++; m_dwell[i] = 1;
      end else if (loop_p[i] != 0) begin
        m_idx[i] = 0; m_dwell[i] = 1;
      end else begin
        m_phase[i] = 2;
      end
    end else if (start) begin
      m_phase[i] = 1; m_idx[i] = 0; m_dwell[i] = 1;
    end
  endtask

  task automatic check_all(input string nm);
    logic [7:0] got, want;
    logic [2:0] wbcd;
    for (int i = 0; i < 2; i++) begin
      wbcd = (m_phase[i] == 0) ? 3'd0 : combo(m_idx[i]);
      got  = {valid_w[i], busy_w[i], done_w[i], b_w[i], c_w[i], d_w[i], 2'b00};
      want = {m_phase[i] == 1, m_phase[i] == 1, m_phase[i] == 2, wbcd, 2'b00};
      n_vec++;
      if (got != want || idx_w[i] != 3'(m_idx[i])) begin
        n_err++;
        $display("FAIL %s dut%0d got v/bsy/dn/bcd=%b idx=%0d want %b idx=%0d",
                 nm, i, got[7:2], idx_w[i], want[7:2], m_idx[i]);
      end
    end
  endtask

  task automatic expect_int(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic tick(input logic st, input logic sp, input logic sm, input logic stp,
                      input logic rdy, input string nm);
    start = st; stop = sp; step_mode = sm; step = stp; ready = rdy;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    @(negedge clk);
    check_all(nm);
  endtask

  task automatic wait_idx(input int d, input int target, input logic sm, input string nm);
    bit seen;
    seen = 0;
    for (int k = 0; k < 80 && !seen; k++) begin
      if (idx_w[d] == 3'(target) && valid_w[d]) seen = 1;
      else tick(0, 0, sm, 0, 1, nm);
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL %s timeout waiting for index %0d", nm, target);
    end
  endtask

  typedef struct {
    logic st, sp, sm, stp, rdy;
    logic ev, eb, ed;
    int   eidx;
  } vec_t;

  vec_t tab [19];

  initial begin
    int vcount, ycount, runlen, nseq;
    logic [2:0] prev;
    logic prev_v, wrap_seen, u1_bad;
    logic [2:0] seq_q [$];

    // Expected outputs of u0 (HOLD 4, no loop) after each applied vector.
    tab[0]  = '{0,0,0,0,1, 0,0,0, 0};
    tab[1]  = '{1,0,0,0,1, 1,1,0, 0};
    tab[2]  = '{0,0,0,0,1, 1,1,0, 0};
    tab[3]  = '{0,0,0,0,1, 1,1,0, 0};
    tab[4]  = '{0,0,0,0,1, 1,1,0, 0};
    tab[5]  = '{0,0,0,0,1, 1,1,0, 1};
    tab[6]  = '{0,0,0,0,0, 1,1,0, 1};
    tab[7]  = '{0,0,0,0,0, 1,1,0, 1};
    tab[8]  = '{0,0,0,0,0, 1,1,0, 1};
    tab[9]  = '{0,0,0,0,0, 1,1,0, 1};
    tab[10] = '{0,0,0,0,1, 1,1,0, 2};
    tab[11] = '{1,0,0,0,1, 1,1,0, 2};
    tab[12] = '{0,0,1,0,1, 1,1,0, 2};
    tab[13] = '{0,0,1,1,0, 1,1,0, 2};
    tab[14] = '{0,0,1,0,1, 1,1,0, 2};
    tab[15] = '{0,0,1,1,1, 1,1,0, 3};
    tab[16] = '{0,0,0,0,1, 1,1,0, 3};
    tab[17] = '{1,1,0,0,1, 0,0,0, 0};
    tab[18] = '{0,0,0,0,1, 0,0,0, 0};

    rst_n = 1'b0;
    start = 0; stop = 0; step_mode = 0; step = 0; ready = 0;
    model_reset();
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      tick(tab[i].st, tab[i].sp, tab[i].sm, tab[i].stp, tab[i].rdy, "table_model");
      expect_int($sformatf("table%0d_out", i),
                 int'({valid_w[0], busy_w[0], done_w[0], b_w[0], c_w[0], d_w[0]}),
                 int'({tab[i].ev, tab[i].eb, tab[i].ed,
                       tab[i].ev ? combo(tab[i].eidx) : 3'd0}));
      expect_int($sformatf("table%0d_idx", i), int'(idx_w[0]), tab[i].eidx);
    end

    // Full auto sweep on u0; u1 loops alongside.
    tick(1, 0, 0, 0, 1, "sweep_start");
    expect_int("sweep_valid_rise", int'(valid_w[0]), 1);
    vcount = 0; ycount = 0; runlen = 0; prev_v = 0; prev = 3'd0;
    wrap_seen = 0; u1_bad = 0;
    for (int k = 0; k < 60 && !done_w[0]; k++) begin
      if (valid_w[0]) begin
        vcount++;
        if ({b_w[0], c_w[0], d_w[0]} inside {3'b001, 3'b101, 3'b111}) ycount++;
        if (prev_v && {b_w[0], c_w[0], d_w[0]} != prev) begin
          expect_int("sweep_dwell", runlen, HOLD0);
`ifdef GRAY_ORDER_EN
          expect_int("gray_one_bit", $countones({b_w[0], c_w[0], d_w[0]} ^ prev), 1);
`endif
          runlen = 0;
        end
        if (!prev_v || {b_w[0], c_w[0], d_w[0]} != prev) seq_q.push_back({b_w[0], c_w[0], d_w[0]});
        runlen++;
        prev = {b_w[0], c_w[0], d_w[0]};
      end
      prev_v = valid_w[0];
      if (!valid_w[1] || done_w[1]) u1_bad = 1;
      tick(0, 0, 0, 0, 1, "sweep");
      if (idx_w[1] == 3'd0 && valid_w[1]) wrap_seen = 1;
    end
    expect_int("sweep_last_dwell", runlen, HOLD0);
    expect_int("sweep_valid_cycles", vcount, 32);
    expect_int("sweep_y_cycles", ycount, 12);
    expect_int("done_flag", int'(done_w[0]), 1);
    expect_int("done_valid", int'(valid_w[0]), 0);
    expect_int("done_index", int'(idx_w[0]), 7);
    expect_int("done_bcd", int'({b_w[0], c_w[0], d_w[0]}), int'(combo(7)));
    nseq = seq_q.size();
    expect_int("sweep_seq_len", nseq, 8);
    for (int k = 0; k < 8 && k < nseq; k++)
      expect_int($sformatf("sweep_seq%0d", k), int'(seq_q[k]), int'(combo(k)));
    expect_int("loop_wrap_seen", int'(wrap_seen), 1);
    expect_int("loop_no_done", int'(u1_bad), 0);

    // Stop together with start while the looping instance sits at index 5.
    wait_idx(1, 5, 0, "wait_u1_idx5");
    tick(1, 1, 0, 0, 1, "stop_start");
    expect_int("stop_u1_valid", int'(valid_w[1]), 0);
    expect_int("stop_u0_done", int'(done_w[0]), 0);

    // Backpressure at index 2 for 10 cycles.
    tick(1, 0, 0, 0, 1, "bp_start");
    wait_idx(0, 2, 0, "wait_u0_idx2");
    for (int k = 0; k < 10; k++) begin
      tick(0, 0, 0, 0, 0, "bp_hold");
      expect_int("bp_hold_bcd", int'({valid_w[0], b_w[0], c_w[0], d_w[0]}), int'({1'b1, combo(2)}));
    end
    tick(0, 0, 0, 0, 1, "bp_release");
    expect_int("bp_release_idx", int'(idx_w[0]), 3);

    // Step mode: three pulses spaced five cycles apart.
    tick(0, 1, 0, 0, 1, "step_stop");
    tick(1, 0, 1, 0, 1, "step_start");
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 4; k++) begin
        tick(0, 0, 1, 0, 1, "step_gap");
        expect_int("step_gap_idx", int'(idx_w[0]), p);
      end
      tick(0, 0, 1, 1, 1, "step_pulse");
      expect_int("step_pulse_idx", int'(idx_w[0]), p + 1);
    end

    // Asynchronous reset between edges at index 3.
    tick(0, 1, 0, 0, 1, "rst_stop");
    tick(1, 0, 0, 0, 1, "rst_start");
    wait_idx(0, 3, 0, "wait_u0_idx3");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    check_all("in_reset");
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) tick(0, 0, 0, 0, 1, "post_reset_idle");

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 15) == 0) step_mode = ~step_mode;
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 40) == 0, step_mode,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
